// File: rtl/fetch_unit_if.sv
// Bus bundle between the fetch controller and its PC unit, instruction memory,
// execute (branch redirect) and decode (valid/ready instruction output).
interface fetch_unit_if;
  logic [15:0] pc_cur;
  logic [1:0]  pc_op;
  logic [15:0] pc_set_val;
  logic        pc_en;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        branch_valid;
  logic [15:0] branch_target;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr_data;
  logic [15:0] instr_pc;

  modport master (
    input  pc_cur, mem_ack, mem_rdata, branch_valid, branch_target, instr_ready,
    output pc_op, pc_set_val, pc_en, mem_req, mem_addr, instr_valid, instr_data, instr_pc
  );

  modport slave (
    output pc_cur, mem_ack, mem_rdata, branch_valid, branch_target, instr_ready,
    input  pc_op, pc_set_val, pc_en, mem_req, mem_addr, instr_valid, instr_data, instr_pc
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch controller: commands the PC unit, reads 16-bit words over req/ack
// and buffers them for decode. Define FETCH_SKID_BUF_EN for a 2-entry output FIFO.
module fetch_unit (
  input  logic         clk,
  input  logic         rst_n,
  fetch_unit_if.master bus
);
  // PC unit command encodings, matching cpu_constants.vh.
  localparam logic [1:0] PC_NOP   = 2'd0;
  localparam logic [1:0] PC_INC   = 2'd1;
  localparam logic [1:0] PC_SET   = 2'd2;
  localparam logic [1:0] PC_RESET = 2'd3;

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        out_q, out_d;
  logic [15:0] addr_q, addr_d;

  logic        hd_vld_q, hd_vld_d;
  logic [15:0] hd_data_q, hd_data_d;
  logic [15:0] hd_pc_q, hd_pc_d;
`ifdef FETCH_SKID_BUF_EN
  logic        tl_vld_q, tl_vld_d;
  logic [15:0] tl_data_q, tl_data_d;
  logic [15:0] tl_pc_q, tl_pc_d;
`endif

  logic        pop;
  logic        full;
  logic        room;
  logic        start;
  logic        push;
  logic        flush;
  logic        req;
  logic [1:0]  op;
  logic [15:0] addr_o;

  assign pop = hd_vld_q & bus.instr_ready;
`ifdef FETCH_SKID_BUF_EN
  assign full = tl_vld_q;
`else
  assign full = hd_vld_q;
`endif
  assign room = ~full | pop;

  // A held request keeps its latched address; a fresh one uses the live PC.
  assign addr_o = out_q ? addr_q : bus.pc_cur;

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    addr_d  = addr_q;
    op      = PC_NOP;
    req     = 1'b0;
    start   = 1'b0;
    push    = 1'b0;
    flush   = 1'b0;
    unique case (state_q)
      S_RESET: begin
        op      = PC_RESET;
        state_d = S_FETCH;
      end
      S_FETCH: begin
        if (bus.branch_valid) begin
          // Redirect wins over ack; an in-flight read is either dropped now or drained.
          op    = PC_SET;
          flush = 1'b1;
          req   = out_q;
          if (out_q) begin
            if (bus.mem_ack) begin
              out_d = 1'b0;
            end else begin
              state_d = S_DRAIN;
            end
          end
        end else begin
          start = ~out_q & room;
          req   = out_q | start;
          if (start) begin
            addr_d = bus.pc_cur;
          end
          if (req) begin
            if (bus.mem_ack) begin
              push  = 1'b1;
              op    = PC_INC;
              out_d = 1'b0;
            end else begin
              out_d = 1'b1;
            end
          end
        end
      end
      S_DRAIN: begin
        req = 1'b1;
        if (bus.branch_valid) begin
          op    = PC_SET;
          flush = 1'b1;
        end
        if (bus.mem_ack) begin
          out_d   = 1'b0;
          state_d = S_FETCH;
        end
      end
      default: begin
        state_d = S_RESET;
      end
    endcase
  end

  always_comb begin
    hd_vld_d  = hd_vld_q;
    hd_data_d = hd_data_q;
    hd_pc_d   = hd_pc_q;
`ifdef FETCH_SKID_BUF_EN
    tl_vld_d  = tl_vld_q;
    tl_data_d = tl_data_q;
    tl_pc_d   = tl_pc_q;
    if (pop) begin
      hd_vld_d  = tl_vld_q;
      hd_data_d = tl_data_q;
      hd_pc_d   = tl_pc_q;
      tl_vld_d  = 1'b0;
    end
    if (push) begin
      if (!hd_vld_d) begin
        hd_vld_d  = 1'b1;
        hd_data_d = bus.mem_rdata;
        hd_pc_d   = addr_o;
      end else begin
        tl_vld_d  = 1'b1;
        tl_data_d = bus.mem_rdata;
        tl_pc_d   = addr_o;
      end
    end
    if (flush) begin
      hd_vld_d = 1'b0;
      tl_vld_d = 1'b0;
    end
`else
    if (pop) begin
      hd_vld_d = 1'b0;
    end
    if (push) begin
      hd_vld_d  = 1'b1;
      hd_data_d = bus.mem_rdata;
      hd_pc_d   = addr_o;
    end
    if (flush) begin
      hd_vld_d = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_RESET;
      out_q     <= 1'b0;
      addr_q    <= 16'h0000;
      hd_vld_q  <= 1'b0;
      hd_data_q <= 16'h0000;
      hd_pc_q   <= 16'h0000;
`ifdef FETCH_SKID_BUF_EN
      tl_vld_q  <= 1'b0;
      tl_data_q <= 16'h0000;
      tl_pc_q   <= 16'h0000;
`endif
    end else begin
      state_q   <= state_d;
      out_q     <= out_d;
      addr_q    <= addr_d;
      hd_vld_q  <= hd_vld_d;
      hd_data_q <= hd_data_d;
      hd_pc_q   <= hd_pc_d;
`ifdef FETCH_SKID_BUF_EN
      tl_vld_q  <= tl_vld_d;
      tl_data_q <= tl_data_d;
      tl_pc_q   <= tl_pc_d;
`endif
    end
  end

  assign bus.pc_op       = op;
  assign bus.pc_set_val  = bus.branch_target;
  assign bus.pc_en       = 1'b1;
  assign bus.mem_req     = req;
  assign bus.mem_addr    = addr_o;
  assign bus.instr_valid = hd_vld_q;
  assign bus.instr_data  = hd_data_q;
  assign bus.instr_pc    = hd_pc_q;
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit (default single-entry build): directed vector table, corner
// sequences, and a random run scored against a program-order reference model.
module tb_fetch_unit;
  localparam logic [1:0] PC_NOP   = 2'd0;
  localparam logic [1:0] PC_INC   = 2'd1;
  localparam logic [1:0] PC_SET   = 2'd2;
  localparam logic [1:0] PC_RESET = 2'd3;

  logic clk = 1'b0;
  logic rst_n;
  fetch_unit_if bus();

  fetch_unit dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  // PC unit model.
  logic [15:0] pc_reg = 16'h1234;
  assign bus.pc_cur = pc_reg;
  always @(posedge clk) begin
    if (bus.pc_en) begin
      case (bus.pc_op)
        PC_INC:   pc_reg <= pc_reg + 16'd2;
        PC_SET:   pc_reg <= bus.pc_set_val;
        PC_RESET: pc_reg <= 16'h0000;
        default:  pc_reg <= pc_reg;
      endcase
    end
  end

  // Memory wait tracking: cycles the current request has already waited.
  int age;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) age <= 0;
    else if (bus.mem_req && !bus.mem_ack) age <= age + 1;
    else age <= 0;
  end

  int pass_cnt = 0;
  int tot_cnt  = 0;
  int lat      = 0;
  int cur_lat  = 0;
  bit rnd_mode = 1'b0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, want %h", nm, act, exp);
  endtask

  task automatic cyc(input bit br, input logic [15:0] tgt, input bit rdy);
    @(negedge clk);
    bus.branch_valid  = br;
    bus.branch_target = tgt;
    bus.instr_ready   = rdy;
    #1;
    if (age == 0) cur_lat = rnd_mode ? int'($urandom_range(0, 3)) : lat;
    bus.mem_ack   = bus.mem_req && (age >= cur_lat);
    bus.mem_rdata = bus.mem_addr ^ 16'hA5A5;
    #1;
  endtask

  task automatic release_rst();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.branch_valid  = 1'b0;
    bus.branch_target = 16'h0000;
    bus.instr_ready   = 1'b1;
    bus.mem_ack       = 1'b0;
    bus.mem_rdata     = 16'h0000;
    lat = 0;
    release_rst();
  endtask

  task automatic chk_out(input string tag, input bit e_req, input logic [15:0] e_addr,
                         input logic [1:0] e_op, input bit e_vld, input logic [15:0] e_pc);
    chk({tag, " req"}, 16'(bus.mem_req), 16'(e_req));
    if (e_req) chk({tag, " addr"}, bus.mem_addr, e_addr);
    chk({tag, " op"}, 16'(bus.pc_op), 16'(e_op));
    chk({tag, " vld"}, 16'(bus.instr_valid), 16'(e_vld));
    if (e_vld) begin
      chk({tag, " ipc"}, bus.instr_pc, e_pc);
      chk({tag, " idata"}, bus.instr_data, e_pc ^ 16'hA5A5);
    end
  endtask

  typedef struct {
    bit          br;
    logic [15:0] tgt;
    bit          rdy;
    bit          e_req;
    logic [15:0] e_addr;
    logic [1:0]  e_op;
    bit          e_vld;
    logic [15:0] e_pc;
    logic [15:0] e_dat;
  } vec_t;

  vec_t vt[19];

  initial begin
    logic [15:0] exp_next, prev_addr, t;
    bit prev_pend, prev_br, br, rdy;
    int accepts;

    vt[0]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, PC_RESET, 1'b0, 16'h0000, 16'h0000};
    vt[1]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0000, PC_INC,   1'b0, 16'h0000, 16'h0000};
    vt[2]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0002, PC_INC,   1'b1, 16'h0000, 16'hA5A5};
    vt[3]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0004, PC_INC,   1'b1, 16'h0002, 16'hA5A7};
    vt[4]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, PC_NOP,   1'b1, 16'h0004, 16'hA5A1};
    vt[5]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, PC_NOP,   1'b1, 16'h0004, 16'hA5A1};
    vt[6]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0006, PC_INC,   1'b1, 16'h0004, 16'hA5A1};
    vt[7]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0008, PC_INC,   1'b1, 16'h0006, 16'hA5A3};
    vt[8]  = '{1'b1, 16'h0100, 1'b0, 1'b0, 16'h0000, PC_SET,   1'b1, 16'h0008, 16'hA5AD};
    vt[9]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0100, PC_INC,   1'b0, 16'h0000, 16'h0000};
    vt[10] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0102, PC_INC,   1'b1, 16'h0100, 16'hA4A5};
    vt[11] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, PC_NOP,   1'b1, 16'h0102, 16'hA4A7};
    vt[12] = '{1'b1, 16'h0200, 1'b0, 1'b0, 16'h0000, PC_SET,   1'b1, 16'h0102, 16'hA4A7};
    vt[13] = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h0200, PC_INC,   1'b0, 16'h0000, 16'h0000};
    vt[14] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, PC_NOP,   1'b1, 16'h0200, 16'hA7A5};
    vt[15] = '{1'b1, 16'hFFFE, 1'b1, 1'b0, 16'h0000, PC_SET,   1'b1, 16'h0200, 16'hA7A5};
    vt[16] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'hFFFE, PC_INC,   1'b0, 16'h0000, 16'h0000};
    vt[17] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0000, PC_INC,   1'b1, 16'hFFFE, 16'h5A5B};
    vt[18] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0002, PC_INC,   1'b1, 16'h0000, 16'hA5A5};

    rst_n = 1'b0;
    bus.branch_valid  = 1'b0;
    bus.branch_target = 16'h0000;
    bus.instr_ready   = 1'b1;
    bus.mem_ack       = 1'b0;
    bus.mem_rdata     = 16'h0000;
    repeat (2) @(negedge clk);
    chk("rst op", 16'(bus.pc_op), 16'(PC_RESET));
    chk("rst req", 16'(bus.mem_req), 16'h0000);
    chk("rst vld", 16'(bus.instr_valid), 16'h0000);
    chk("rst idata", bus.instr_data, 16'h0000);
    chk("rst ipc", bus.instr_pc, 16'h0000);

    // Directed vector table, zero-wait memory.
    release_rst();
    for (int i = 0; i < 19; i++) begin
      cyc(vt[i].br, vt[i].tgt, vt[i].rdy);
      chk($sformatf("v%0d req", i), 16'(bus.mem_req), 16'(vt[i].e_req));
      if (vt[i].e_req) chk($sformatf("v%0d addr", i), bus.mem_addr, vt[i].e_addr);
      chk($sformatf("v%0d op", i), 16'(bus.pc_op), 16'(vt[i].e_op));
      chk($sformatf("v%0d vld", i), 16'(bus.instr_valid), 16'(vt[i].e_vld));
      if (vt[i].e_vld) begin
        chk($sformatf("v%0d ipc", i), bus.instr_pc, vt[i].e_pc);
        chk($sformatf("v%0d idata", i), bus.instr_data, vt[i].e_dat);
      end
    end

    // Branch while the read of 0x0004 waits on a 3-cycle ack.
    do_reset();
    cyc(1'b0, 16'h0, 1'b1); chk_out("dr0", 1'b0, 16'h0000, PC_RESET, 1'b0, 16'h0);
    cyc(1'b0, 16'h0, 1'b1); chk_out("dr1", 1'b1, 16'h0000, PC_INC, 1'b0, 16'h0);
    cyc(1'b0, 16'h0, 1'b1); chk_out("dr2", 1'b1, 16'h0002, PC_INC, 1'b1, 16'h0000);
    lat = 2;
    cyc(1'b0, 16'h0, 1'b1); chk_out("dr3", 1'b1, 16'h0004, PC_NOP, 1'b1, 16'h0002);
    cyc(1'b1, 16'h0100, 1'b1); chk_out("dr4", 1'b1, 16'h0004, PC_SET, 1'b0, 16'h0);
    cyc(1'b0, 16'h0, 1'b1); chk_out("dr5", 1'b1, 16'h0004, PC_NOP, 1'b0, 16'h0);
    lat = 0;
    cyc(1'b0, 16'h0, 1'b1); chk_out("dr6", 1'b1, 16'h0100, PC_INC, 1'b0, 16'h0);
    cyc(1'b0, 16'h0, 1'b1); chk_out("dr7", 1'b1, 16'h0102, PC_INC, 1'b1, 16'h0100);

    // Branch in the same cycle as the ack: data dropped, no drain.
    do_reset();
    cyc(1'b0, 16'h0, 1'b1); chk_out("ba0", 1'b0, 16'h0000, PC_RESET, 1'b0, 16'h0);
    cyc(1'b0, 16'h0, 1'b1); chk_out("ba1", 1'b1, 16'h0000, PC_INC, 1'b0, 16'h0);
    lat = 1;
    cyc(1'b0, 16'h0, 1'b1); chk_out("ba2", 1'b1, 16'h0002, PC_NOP, 1'b1, 16'h0000);
    cyc(1'b1, 16'h0300, 1'b1); chk_out("ba3", 1'b1, 16'h0002, PC_SET, 1'b0, 16'h0);
    cyc(1'b0, 16'h0, 1'b1); chk_out("ba4", 1'b1, 16'h0300, PC_NOP, 1'b0, 16'h0);
    cyc(1'b0, 16'h0, 1'b1); chk_out("ba5", 1'b1, 16'h0300, PC_INC, 1'b0, 16'h0);
    lat = 0;
    cyc(1'b0, 16'h0, 1'b1); chk_out("ba6", 1'b1, 16'h0302, PC_INC, 1'b1, 16'h0300);

    // Reset dropped mid-request, between clock edges.
    do_reset();
    cyc(1'b0, 16'h0, 1'b1);
    cyc(1'b0, 16'h0, 1'b1); chk_out("mr1", 1'b1, 16'h0000, PC_INC, 1'b0, 16'h0);
    lat = 4;
    cyc(1'b0, 16'h0, 1'b1); chk_out("mr2", 1'b1, 16'h0002, PC_NOP, 1'b1, 16'h0000);
    cyc(1'b0, 16'h0, 1'b1); chk_out("mr3", 1'b1, 16'h0002, PC_NOP, 1'b0, 16'h0);
    #1 rst_n = 1'b0;
    #1;
    chk("mr async req", 16'(bus.mem_req), 16'h0000);
    chk("mr async vld", 16'(bus.instr_valid), 16'h0000);
    chk("mr async op", 16'(bus.pc_op), 16'(PC_RESET));
    bus.mem_ack = 1'b0;
    lat = 0;
    release_rst();
    cyc(1'b0, 16'h0, 1'b1); chk_out("mr4", 1'b0, 16'h0000, PC_RESET, 1'b0, 16'h0);
    cyc(1'b0, 16'h0, 1'b1); chk_out("mr5", 1'b1, 16'h0000, PC_INC, 1'b0, 16'h0);
    cyc(1'b0, 16'h0, 1'b1); chk_out("mr6", 1'b1, 16'h0002, PC_INC, 1'b1, 16'h0000);

    // Random run: accepted instructions must follow program order, redirected by branches.
    do_reset();
    rnd_mode  = 1'b1;
    cyc(1'b0, 16'h0, 1'b1);
    exp_next  = 16'h0000;
    prev_pend = 1'b0;
    prev_addr = 16'h0000;
    prev_br   = 1'b0;
    accepts   = 0;
    for (int n = 0; n < 3000; n++) begin
      br  = ($urandom_range(0, 99) < 6);
      rdy = ($urandom_range(0, 3) != 0);
      t   = 16'($urandom_range(0, 65535));
      t[0] = 1'b0;
      cyc(br, t, rdy);
      chk("rnd en", 16'(bus.pc_en), 16'h0001);
      if (bus.mem_req) chk("rnd addr even", 16'(bus.mem_addr[0]), 16'h0000);
      if (prev_br) chk("rnd flush", 16'(bus.instr_valid), 16'h0000);
      if (prev_pend) begin
        chk("rnd hold req", 16'(bus.mem_req), 16'h0001);
        chk("rnd hold addr", bus.mem_addr, prev_addr);
      end
      if (br) begin
        chk("rnd set op", 16'(bus.pc_op), 16'(PC_SET));
        chk("rnd set val", bus.pc_set_val, t);
      end else begin
        chk("rnd no set", 16'(bus.pc_op == PC_SET), 16'h0000);
      end
      if (bus.instr_valid && rdy) begin
        chk("rnd ipc", bus.instr_pc, exp_next);
        chk("rnd idata", bus.instr_data, bus.instr_pc ^ 16'hA5A5);
        exp_next = bus.instr_pc + 16'd2;
        accepts++;
      end
`ifndef FETCH_SKID_BUF_EN
      if (bus.instr_valid && !rdy) chk("rnd stall req", 16'(bus.mem_req), 16'h0000);
`endif
      if (br) exp_next = t;
      prev_pend = bus.mem_req && !bus.mem_ack;
      prev_addr = bus.mem_addr;
      prev_br   = br;
    end
    chk("rnd progress", 16'(accepts >= 200), 16'h0001);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch controller that drives the PC unit's `pc_op`/`pc_in` command interface and consumes its `pc_out`. It issues 16-bit instruction reads to memory over a req/ack handshake and presents fetched words to decode through a valid/ready output. It also applies branch redirects from execute by commanding the PC unit.

## Interface
- No parameters. PC op encodings (`PC_NOP`, `PC_INC`, `PC_SET`, `PC_RESET`) come from `cpu_constants.vh`.
- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `pc_cur`  in  16  current PC; connects to the PC unit's `pc_out`
- `pc_op`  out  2  command to the PC unit
- `pc_set_val`  out  16  target for `PC_SET`; connects to the PC unit's `pc_in`
- `pc_en`  out  1  enable to the PC unit
- `mem_req`  out  1  read request
- `mem_addr`  out  16  byte address, always even
- `mem_ack`  in  1  read complete; `mem_rdata` is valid in the same cycle
- `mem_rdata`  in  16  instruction word
- `branch_valid`  in  1  single-cycle redirect strobe
- `branch_target`  in  16  redirect address, even
- `instr_valid`  out  1  an instruction is available
- `instr_ready`  in  1  decode accepts the instruction
- `instr_data`  out  16  instruction word
- `instr_pc`  out  16  address the instruction was fetched from

## Operation
- States: S_RESET, S_FETCH, S_DRAIN.
- S_RESET: entered while `rst_n`=0.
  - On the first clock after release, drives `pc_op=PC_RESET` and `pc_en=1`, then moves to S_FETCH.
  - `branch_valid` is ignored in S_RESET.
- S_FETCH starting a request:
  - A new request starts when no request is outstanding and the buffer has room.
  - The buffer has room when it is not full, or when its head is being popped this cycle (`instr_valid & instr_ready`).
  - In the start cycle, `mem_addr` = `pc_cur` and is latched into `addr_q`.
- S_FETCH while a request is outstanding:
  - `mem_req` stays 1 and `mem_addr` = `addr_q`, held stable, until `mem_ack`.
- S_FETCH on `mem_ack`:
  - Pushes {`mem_rdata`, `addr_q`} into the buffer.
  - Drives `pc_op=PC_INC` and `pc_en=1`.
  - `mem_req` may restart in the next cycle.
- Idle cycles: `pc_op=PC_NOP` and `pc_en=1`.
- Branch (`branch_valid`=1, state not S_RESET):
  - Drives `pc_op=PC_SET`, `pc_set_val=branch_target`, `pc_en=1`.
  - Flushes the buffer; `instr_valid`=0 next cycle.
  - If a request is outstanding and `mem_ack`=0, goes to S_DRAIN.
- S_DRAIN:
  - `mem_req` stays 1 with the old `addr_q` until `mem_ack`.
  - The returned data is discarded and no `PC_INC` is issued.
  - After the ack, returns to S_FETCH.
- Priority, highest first: branch, then ack, then idle.
  - Branch in the same cycle as `mem_ack`: the data is discarded, `PC_SET` is issued (not `PC_INC`), and the state stays S_FETCH.
  - A second `branch_valid` in S_DRAIN issues a new `PC_SET`; drain continues.
  - A pop in the same cycle as a branch is still accepted by decode; the flush occurs after it.
- Buffer: one entry by default (see Configuration). It is never pushed when full.

## Timing
- Combinational outputs, from state and inputs: `pc_op`, `pc_set_val`, `pc_en`, `mem_req`, `mem_addr`. The PC unit updates at the following edge.
- Registered outputs: `instr_valid`, `instr_data`, `instr_pc`.
- Reset values: `instr_valid`=0, `instr_data`=0, `instr_pc`=0, `addr_q`=0, state S_RESET.
  - While in reset, the combinational outputs are `mem_req`=0 and `pc_op=PC_RESET`.
- Latency: `mem_ack` in cycle N gives `instr_valid`=1 in cycle N+1.
- Throughput with zero-wait memory (ack in the request cycle) and `instr_ready`=1: one instruction per cycle.
- Branch strobe in cycle N with no outstanding request: `mem_req` with `mem_addr=branch_target` in cycle N+1.
- Address arithmetic is 16-bit modulo: 0xFFFE + 2 wraps to 0x0000 with no special handling.
- Asserting `rst_n` mid-request: state, buffer and `addr_q` clear immediately; the pending ack is not awaited.

## Configuration
- `FETCH_SKID_BUF_EN` defined: the buffer is a 2-entry FIFO.
  - Fetch continues while decode stalls, until two entries are held.
  - Pop order is FIFO; a flush clears both entries.
- `FETCH_SKID_BUF_EN` undefined: single-entry buffer.
  - With `instr_ready`=0 and one entry held, no new request starts.

## Test plan
- Release reset; zero-wait memory returning `mem_rdata` = address XOR 0xA5A5; `instr_ready`=1 -> `mem_addr` 0x0000, 0x0002, 0x0004 on consecutive cycles; `instr_pc` 0, 2, 4 with matching data one cycle later.
- Hold `instr_ready`=0 after the first fetch (single-entry build) -> `mem_req`=0 and the PC stays at 0x0002. Raise `instr_ready` -> `instr_data` for 0x0000 pops and the fetch of 0x0002 resumes the same cycle.
- Idle pipe; `branch_valid` with target 0x0100 -> `pc_op=PC_SET` in that cycle; next `mem_addr`=0x0100; the buffered instruction is flushed.
- Branch to 0x0100 while a request to 0x0004 waits on a 3-cycle ack -> `mem_addr` holds 0x0004 until ack; that data is never presented; next request is to 0x0100.
- `branch_valid` in the same cycle as `mem_ack` -> `pc_op=PC_SET` (not `PC_INC`); the ack data is dropped.
- Drop `rst_n` during an outstanding request -> without a clock edge, `mem_req`=0 and `instr_valid`=0. After release, fetch restarts at 0x0000.
